// File: rtl/sig_pkg.sv
// Shared constants and round-robin pick helper for the signed multiplier arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: SIG_W operand width, SIG_PW product width, rr_pick(valid, ptr, nreq) -> {found, index}.
package sig_pkg;

   localparam int SIG_W  = 4;
   localparam int SIG_PW = 8;

   // Returns {found, index[2:0]} for the first set bit of valid[nreq-1:0]
   // searching ptr, ptr+1, ... with wrap at nreq. Supports up to 8 requesters.
   // The loop runs from the farthest offset down to offset 0, so the nearest
   // valid requester to ptr is the one that sticks.
   function automatic logic [3:0] rr_pick(input logic [7:0]  valid,
                                          input logic [2:0]  ptr,
                                          input int unsigned nreq);
      logic [3:0] res;
      int         idx;
      res = 4'h0;
      for (int k = 7; k >= 0; k--) begin
         idx = int'(ptr) + k;
         // ptr < nreq and k < nreq, so one subtraction is enough to wrap
         if (idx >= int'(nreq)) idx = idx - int'(nreq);
         if ((k < int'(nreq)) && valid[idx[2:0]]) res = {1'b1, idx[2:0]};
      end
      return res;
   endfunction

endpackage

// File: rtl/sig_mul_arbiter_sig.sv
// Signed 4x4 -> 8 multiplier (SIG), full-precision two's complement product.
// Latency: combinational, 0 cycles.
// Backpressure: none; the enclosing pipeline holds the operands when stalled.
// Ports: iX1, iX2 signed operands; oY signed product.
module sig_mul_arbiter_sig
   import sig_pkg::*;
(
   input  logic [SIG_W-1:0]  iX1,
   input  logic [SIG_W-1:0]  iX2,
   output logic [SIG_PW-1:0] oY
);

   logic signed [SIG_PW-1:0] x1_ext;
   logic signed [SIG_PW-1:0] x2_ext;

   // Sign-extend to product width; the low SIG_PW bits of the product are
   // then exact for every 4-bit operand pair (-8*-8 = +64 fits).
   assign x1_ext = {{(SIG_PW-SIG_W){iX1[SIG_W-1]}}, iX1};
   assign x2_ext = {{(SIG_PW-SIG_W){iX2[SIG_W-1]}}, iX2};
   assign oY     = x1_ext * x2_ext;

endmodule

// File: rtl/sig_mul_arbiter.sv
// Round-robin arbiter sharing one signed 4x4 multiplier among NREQ requesters.
// Latency: 2 cycles from request transfer to oRspValid, plus one per stall cycle.
// Backpressure: oRspValid & ~iRspReady freezes both stages and drops all oReqReady.
// Ports: iClk/iRst (sync, active-high); iReqValid/iReqX1/iReqX2 in, oReqReady out
//        per requester; oRspValid/oRspId/oRspY out, iRspReady in for the response.
module sig_mul_arbiter
   import sig_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
)(
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic [NREQ-1:0]       iReqValid,
   input  logic [SIG_W*NREQ-1:0] iReqX1,
   input  logic [SIG_W*NREQ-1:0] iReqX2,
   output logic [NREQ-1:0]       oReqReady,
   output logic                  oRspValid,
   output logic [IDW-1:0]        oRspId,
   output logic [SIG_PW-1:0]     oRspY,
   input  logic                  iRspReady
);

   logic [IDW-1:0]    ptr;
   logic [IDW-1:0]    ptr_nxt;
   logic [7:0]        valid_pad;
   logic [3:0]        pick;
   logic [2:0]        pick_idx;
   logic              grant_vld;
   logic [IDW-1:0]    grant_id;
   logic              stall;

   // stage A: operand register
   logic              a_vld;
   logic [IDW-1:0]    a_id;
   logic [SIG_W-1:0]  a_x1;
   logic [SIG_W-1:0]  a_x2;
   logic [SIG_PW-1:0] a_y;

   assign stall = oRspValid & ~iRspReady;

   always_comb begin
      valid_pad = '0;
      valid_pad[NREQ-1:0] = iReqValid;
   end

   assign pick      = rr_pick(valid_pad, 3'(ptr), NREQ);
   assign pick_idx  = pick[2:0];
   assign grant_id  = IDW'(pick_idx);
   // A grant is always to a valid requester, so grant_vld is also "transfer"
   assign grant_vld = pick[3] & ~stall & ~iRst;

   always_comb begin
      oReqReady = '0;
      if (grant_vld) oReqReady[grant_id] = 1'b1;
   end

   assign ptr_nxt = (int'(grant_id) == NREQ-1) ? '0 : grant_id + IDW'(1);

   sig_mul_arbiter_sig u_sig (
      .iX1 (a_x1),
      .iX2 (a_x2),
      .oY  (a_y)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         ptr       <= '0;
         a_vld     <= 1'b0;
         a_id      <= '0;
         a_x1      <= '0;
         a_x2      <= '0;
         oRspValid <= 1'b0;
         oRspId    <= '0;
         oRspY     <= '0;
      end else if (!stall) begin
         if (grant_vld) ptr <= ptr_nxt;
         // Operands are captured even without a grant; only a_vld matters then
         a_vld     <= grant_vld;
         a_id      <= grant_id;
         a_x1      <= iReqX1[int'(grant_id)*SIG_W +: SIG_W];
         a_x2      <= iReqX2[int'(grant_id)*SIG_W +: SIG_W];
         oRspValid <= a_vld;
         oRspId    <= a_id;
         oRspY     <= a_y;
      end
   end

endmodule

// File: tb/tb_sig_mul_arbiter.sv
// Directed self-checking bench for sig_mul_arbiter (NREQ=4).
// Latency: inputs driven at negedge, outputs checked 1 time unit later.
// Backpressure: exercised by holding iRspReady low with a valid response.
module tb_sig_mul_arbiter;

   logic        iClk;
   logic        iRst;
   logic [3:0]  iReqValid;
   logic [15:0] iReqX1;
   logic [15:0] iReqX2;
   logic [3:0]  oReqReady;
   logic        oRspValid;
   logic [1:0]  oRspId;
   logic [7:0]  oRspY;
   logic        iRspReady;

   int n_cmp = 0;
   int n_err = 0;

   sig_mul_arbiter #(.NREQ(4)) dut (
      .iClk      (iClk),
      .iRst      (iRst),
      .iReqValid (iReqValid),
      .iReqX1    (iReqX1),
      .iReqX2    (iReqX2),
      .oReqReady (oReqReady),
      .oRspValid (oRspValid),
      .oRspId    (oRspId),
      .oRspY     (oRspY),
      .iRspReady (iRspReady)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge iClk);
   endtask

   task automatic set_op(input int r, input logic [3:0] a, input logic [3:0] b);
      iReqX1[4*r +: 4] = a;
      iReqX2[4*r +: 4] = b;
   endtask

   task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [7:0] y);
      chk({tag, "_vld"}, 32'(oRspValid), 32'd1);
      chk({tag, "_id"},  32'(oRspId),    32'(id));
      chk({tag, "_y"},   32'(oRspY),     32'(y));
   endtask

   logic [3:0] c_x1 [5] = '{4'h8, 4'h7, 4'h7, 4'h0, 4'hF};
   logic [3:0] c_x2 [5] = '{4'h8, 4'h8, 4'h7, 4'h8, 4'hF};
   logic [7:0] c_y  [5] = '{8'h40, 8'hC8, 8'h31, 8'h00, 8'h01};
   int         g_ord [6] = '{0, 1, 2, 3, 0, 1};
   logic [7:0] ex_y  [256];
   logic [1:0] ex_id [256];

   initial begin
      iRst      = 1'b1;
      iReqValid = 4'hF;
      iReqX1    = '0;
      iReqX2    = '0;
      iRspReady = 1'b1;

      // 1: reset
      tick(); tick(); #1;
      chk("rst_ready", 32'(oReqReady), 32'h0);
      chk("rst_vld",   32'(oRspValid), 32'h0);
      chk("rst_y",     32'(oRspY),     32'h0);
      chk("rst_id",    32'(oRspId),    32'h0);
      iRst = 1'b0;
      #1;
      chk("first_grant", 32'(oReqReady), 32'h1);
      iReqValid = 4'h0;

      // 2: single request from req2, 3 * -2 = -6
      tick();
      iReqValid = 4'b0100;
      set_op(2, 4'h3, 4'hE);
      #1 chk("single_ready", 32'(oReqReady), 32'b0100);
      tick();
      iReqValid = 4'h0;
      #1 chk("single_c1_vld", 32'(oRspValid), 32'h0);
      tick(); #1;
      chk_rsp("single_c2", 2'd2, 8'hFA);

      // 3: corner products through req0, back to back
      for (int k = 0; k < 7; k++) begin
         tick();
         if (k < 5) begin
            iReqValid = 4'b0001;
            set_op(0, c_x1[k], c_x2[k]);
         end else begin
            iReqValid = 4'h0;
         end
         #1;
         if (k < 5) chk("corner_ready", 32'(oReqReady), 32'h1);
         if (k >= 2) chk_rsp("corner", 2'd0, c_y[k-2]);
      end

      // 4: fairness; req3 alone first to bring the pointer back to 0
      tick();
      iReqValid = 4'b1000;
      for (int i = 0; i < 4; i++) set_op(i, 4'(i+1), 4'h2);
      #1 chk("fair_setup_ready", 32'(oReqReady), 32'b1000);
      for (int k = 0; k < 8; k++) begin
         tick();
         iReqValid = (k < 6) ? 4'hF : 4'h0;
         #1;
         if (k < 6) chk("fair_grant", 32'(oReqReady), 32'(1 << g_ord[k]));
         if (k == 1) chk_rsp("fair_setup_rsp", 2'd3, 8'h08);
         if (k >= 2) chk_rsp("fair_rsp", 2'(g_ord[k-2]), 8'(2*(g_ord[k-2]+1)));
      end

      // 5: backpressure; pointer is at 2
      tick(); iReqValid = 4'hF;
      #1 chk("bp_t0_ready", 32'(oReqReady), 32'b0100);
      tick();
      #1 chk("bp_t1_ready", 32'(oReqReady), 32'b1000);
      for (int k = 0; k < 3; k++) begin
         tick();
         iRspReady = 1'b0;
         #1;
         chk("bp_stall_ready", 32'(oReqReady), 32'h0);
         chk_rsp("bp_stall", 2'd2, 8'h06);
      end
      tick();
      iRspReady = 1'b1;
      #1;
      chk("bp_release_ready", 32'(oReqReady), 32'b0001);
      chk_rsp("bp_release", 2'd2, 8'h06);
      tick();
      iReqValid = 4'h0;
      #1 chk_rsp("bp_next", 2'd3, 8'h08);
      tick();
      #1 chk_rsp("bp_last", 2'd0, 8'h02);
      tick();
      #1 chk("bp_drained", 32'(oRspValid), 32'h0);

      // 6: reset mid-flight; pointer is at 1
      tick(); iReqValid = 4'hF;
      #1 chk("mid_u0_ready", 32'(oReqReady), 32'b0010);
      tick();
      #1 chk("mid_u1_ready", 32'(oReqReady), 32'b0100);
      tick();
      iRst = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(oReqReady), 32'h0);
      chk("mid_rst_vld",   32'(oRspValid), 32'h1);
      tick();
      iRst = 1'b0;
      #1;
      chk("mid_after_vld",   32'(oRspValid), 32'h0);
      chk("mid_after_y",     32'(oRspY),     32'h0);
      chk("mid_after_ready", 32'(oReqReady), 32'b0001);
      iReqValid = 4'h0;
      for (int k = 0; k < 2; k++) begin
         tick();
         #1 chk("mid_no_ghost", 32'(oRspValid), 32'h0);
      end

      // 7: full operand sweep, one requester per cycle
      for (int n = 0; n < 258; n++) begin
         tick();
         if (n < 256) begin
            logic [7:0] nb;
            logic [3:0] x1, x2;
            int pa, pb, r;
            nb = 8'(n);
            x1 = nb[7:4];
            x2 = nb[3:0];
            r  = n % 4;
            pa = $signed(x1);
            pb = $signed(x2);
            ex_y[n]  = 8'(pa * pb);
            ex_id[n] = 2'(r);
            iReqValid = 4'(1 << r);
            set_op(r, x1, x2);
         end else begin
            iReqValid = 4'h0;
         end
         #1;
         if (n < 256) chk("sweep_ready", 32'(oReqReady), 32'(iReqValid));
         if (n >= 2) chk_rsp("sweep", ex_id[n-2], ex_y[n-2]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
